// File: rtl/gl_fetch_stream.sv
// Command-stream fetcher: walks a command list held in a synchronous BRAM
// and presents it one word at a time on a valid/ready stream, tagging
// the header (first), the final word (last) and the word index.
// JUMP redirects fetching and END parks the block in HALT.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// FETCH | inst_addr presented to the BRAM for one cycle
// LATCH | BRAM data captured into out_word, header decoded
// OUT   | word offered downstream, waiting for out_ready
// HALT  | END consumed, done=1, inst_addr held until next start
module gl_fetch_stream #(
    parameter int               DATA_W      = 32,
    parameter int               ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] TEXT_START = '0,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stall,
    input  logic [DATA_W-1:0] inst_in,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic [4:0]        out_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_OUT   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [7:0] OP_JUMP = 8'h20;
    localparam logic [7:0] OP_END  = 8'h21;

    // Words per command, header included; unknown opcodes are single-word.
    function automatic logic [4:0] cmd_len(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                      cmd_len = 5'd4;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: cmd_len = 5'd17;
            8'h19:                             cmd_len = 5'd5;
            8'h1A:                             cmd_len = 5'd7;
            8'h20:                             cmd_len = 5'd2;
            default:                           cmd_len = 5'd1;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [4:0]        len_q, len_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              jump_q, jump_d;
    logic              end_q, end_d;
    logic              done_q, done_d;

    logic [4:0]        cur_len;
    logic [ADDR_W-1:0] jump_tgt;

    // State register; stall is folded into the next-state logic so every
    // register simply reloads itself while frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= TEXT_START;
            word_q  <= RESET_VALUE;
            cnt_q   <= '0;
            len_q   <= 5'd1;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            jump_q  <= 1'b0;
            end_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            first_q <= first_d;
            last_q  <= last_d;
            jump_q  <= jump_d;
            end_q   <= end_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        first_d  = first_q;
        last_d   = last_q;
        jump_d   = jump_q;
        end_d    = end_q;
        done_d   = done_q;
        cur_len  = len_q;
        jump_tgt = ADDR_W'(word_q) & {{(ADDR_W-2){1'b1}}, 2'b00};

        if (!stall) begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_d = S_FETCH;
                        addr_d  = TEXT_START;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end
                end
                S_FETCH: begin
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    word_d = inst_in;
                    if (cnt_q == 5'd0) begin
                        cur_len = cmd_len(inst_in[7:0]);
                        len_d   = cur_len;
                        jump_d  = (inst_in[7:0] == OP_JUMP);
                        end_d   = (inst_in[7:0] == OP_END);
                    end
                    first_d = (cnt_q == 5'd0);
                    last_d  = (cnt_q == cur_len - 5'd1);
                    state_d = S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (!last_q) begin
                            addr_d  = addr_q + ADDR_W'(4);
                            cnt_d   = cnt_q + 5'd1;
                            state_d = S_FETCH;
                        end else if (end_q) begin
                            done_d  = 1'b1;
                            state_d = S_HALT;
                        end else if (jump_q) begin
                            addr_d  = jump_tgt;
                            cnt_d   = '0;
                            state_d = S_FETCH;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(4);
                            cnt_d   = '0;
                            state_d = S_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Stream outputs are taken straight from state so they cannot change
    // while a word waits for out_ready.
    always_comb begin
        inst_addr = addr_q;
        out_word  = word_q;
        out_valid = (state_q == S_OUT);
        out_first = first_q;
        out_last  = last_q;
        out_idx   = cnt_q;
        busy      = (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_OUT);
        done      = done_q;
    end

endmodule

// File: tb/tb_gl_fetch_stream.sv
// Bench for gl_fetch_stream: BRAM model, command-list reference model,
// directed scenarios plus randomized programs/handshakes.
module tb_gl_fetch_stream;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] inst_in = '0;
    logic [31:0] inst_addr;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_first;
    logic        out_last;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    gl_fetch_stream #(
        .DATA_W(32), .ADDR_W(32), .TEXT_START(32'h0), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
        .inst_in(inst_in), .inst_addr(inst_addr),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];

    always @(posedge clk) inst_in <= mem[inst_addr[9:2]];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        first;
        logic        last;
        logic [31:0] next_addr;
    } exp_t;

    exp_t exp_q[$];

    function automatic int cmd_len(input logic [7:0] op);
        case (op)
            8'h03, 8'h04: return 4;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: return 17;
            8'h19: return 5;
            8'h1A: return 7;
            8'h20: return 2;
            default: return 1;
        endcase
    endfunction

    // Walk the command list in memory and list every word the stream must carry.
    task automatic build_model(input logic [31:0] pc0, input int maxw);
        logic [31:0] pc;
        logic [31:0] a;
        logic [7:0]  op;
        int          len;
        exp_t        e;
        pc = pc0;
        exp_q.delete();
        while (exp_q.size() < maxw) begin
            op  = mem[pc[9:2]][7:0];
            len = cmd_len(op);
            for (int k = 0; k < len && exp_q.size() < maxw; k++) begin
                a = pc + 32'(4 * k);
                e.data  = mem[a[9:2]];
                e.idx   = 5'(k);
                e.first = (k == 0);
                e.last  = (k == len - 1);
                if (k < len - 1)    e.next_addr = a + 32'd4;
                else if (op == 8'h20) e.next_addr = e.data & ~32'h3;
                else if (op == 8'h21) e.next_addr = a;
                else                e.next_addr = a + 32'd4;
                exp_q.push_back(e);
            end
            if (op == 8'h21) break;
            pc = exp_q[$].next_addr;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Consume n words. rmode: 0 ready held, 1 toggling, 2 random.
    // smode: 0 no stall, 1 random stall and stray start, 2 five-cycle stall on first valid word.
    task automatic drain(input int n, input int rmode, input int smode);
        int got = 0, cyc = 0, last_hs = -1, burst = 0;
        int budget;
        bit chk_prev = 0, ps = 0, phold = 0, addr_chk = 0, burst_done = 0, hs;
        bit tog = 1;
        logic [31:0] p_word, p_addr, exp_addr;
        logic        p_valid, p_first, p_last, p_busy, p_done;
        logic [4:0]  p_idx;
        exp_t        e;
        budget = n * 40 + 60;
        while (got < n && cyc < budget) begin
            if (chk_prev && ps) begin
                checks++;
                if (out_valid !== p_valid || out_word !== p_word || inst_addr !== p_addr ||
                    out_first !== p_first || out_last !== p_last || out_idx !== p_idx ||
                    busy !== p_busy || done !== p_done) begin
                    failures++;
                    $display("FAIL stall_freeze: got valid=%b word=%h addr=%h idx=%0d busy=%b, required valid=%b word=%h addr=%h idx=%0d busy=%b",
                             out_valid, out_word, inst_addr, out_idx, busy, p_valid, p_word, p_addr, p_idx, p_busy);
                end
            end else if (chk_prev && phold) begin
                checks++;
                if (out_valid !== 1'b1 || out_word !== p_word || out_first !== p_first ||
                    out_last !== p_last || out_idx !== p_idx) begin
                    failures++;
                    $display("FAIL hold_stable: got valid=%b word=%h first=%b last=%b idx=%0d, required valid=1 word=%h first=%b last=%b idx=%0d",
                             out_valid, out_word, out_first, out_last, out_idx, p_word, p_first, p_last, p_idx);
                end
            end
            if (addr_chk) begin
                checks++;
                if (inst_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL next_addr: got %h required %h", inst_addr, exp_addr);
                end
                addr_chk = 0;
            end
            stall = 1'b0;
            start = 1'b0;
            if (smode == 1) begin
                stall = ($urandom_range(0, 9) == 0);
                if (busy) start = ($urandom_range(0, 3) == 0);
            end else if (smode == 2 && out_valid && !burst_done) begin
                stall = 1'b1;
                burst++;
                if (burst == 5) burst_done = 1;
            end
            if (rmode == 0)      out_ready = 1'b1;
            else if (rmode == 1) begin out_ready = tog; tog = ~tog; end
            else                 out_ready = $urandom_range(0, 1);
            if (smode == 2 && stall) out_ready = 1'b1;
            hs = out_valid && out_ready && !stall;
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word: got word=%h required no further word", out_word);
                end else begin
                    e = exp_q.pop_front();
                    if (out_word !== e.data || out_idx !== e.idx || out_first !== e.first ||
                        out_last !== e.last || busy !== 1'b1) begin
                        failures++;
                        $display("FAIL stream_word: got word=%h idx=%0d first=%b last=%b busy=%b, required word=%h idx=%0d first=%b last=%b busy=1",
                                 out_word, out_idx, out_first, out_last, busy, e.data, e.idx, e.first, e.last);
                    end
                    exp_addr = e.next_addr;
                    addr_chk = 1;
                end
                if (rmode == 0 && smode == 0 && last_hs >= 0) begin
                    checks++;
                    if (cyc - last_hs != 3) begin
                        failures++;
                        $display("FAIL throughput: got gap %0d required 3", cyc - last_hs);
                    end
                end
                last_hs = cyc;
                got++;
            end
            p_word = out_word; p_addr = inst_addr; p_valid = out_valid; p_first = out_first;
            p_last = out_last; p_idx = out_idx; p_busy = busy; p_done = done;
            chk_prev = 1; ps = stall; phold = out_valid && !hs;
            @(posedge clk); #1;
            cyc++;
        end
        stall = 1'b0; out_ready = 1'b0; start = 1'b0;
        checks++;
        if (got < n) begin
            failures++;
            $display("FAIL drain_timeout: got %0d words required %0d", got, n);
        end
        if (addr_chk) begin
            checks++;
            if (inst_addr !== exp_addr) begin
                failures++;
                $display("FAIL next_addr: got %h required %h", inst_addr, exp_addr);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || inst_addr !== 32'h0 ||
            out_word !== RV || out_first !== 1'b0 || out_last !== 1'b0 || out_idx !== 5'd0) begin
            failures++;
            $display("FAIL %s: got valid=%b busy=%b done=%b addr=%h word=%h first=%b last=%b idx=%0d, required 0 0 0 00000000 %h 0 0 0",
                     tag, out_valid, busy, done, inst_addr, out_word, out_first, out_last, out_idx, RV);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_vals("reset_state");
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("idle_without_start");
    endtask

    task automatic test_vertex();
        fill_random();
        mem[0] = 32'h0000_0003;
        do_reset();
        build_model(32'h0, 4);
        pulse_start();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || inst_addr !== 32'h0) begin
            failures++;
            $display("FAIL vertex_fetch: got valid=%b busy=%b addr=%h required 0 1 00000000", out_valid, busy, inst_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL vertex_latch: got valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL vertex_latency: got valid=%b required 1", out_valid);
        end
        drain(4, 0, 0);
        checks++;
        if (inst_addr !== 32'd16) begin
            failures++;
            $display("FAIL vertex_next: got %h required 00000010", inst_addr);
        end
    endtask

    task automatic test_loadmatrix();
        fill_random();
        mem[0] = 32'h0000_0013;
        do_reset();
        build_model(32'h0, 18);
        pulse_start();
        drain(18, 1, 0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL loadmatrix_left: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_jump();
        fill_random();
        mem[0] = 32'h0000_0020;
        mem[1] = 32'h0000_0103;
        mem[64] = 32'h0000_0004;
        do_reset();
        build_model(32'h0, 6);
        pulse_start();
        drain(6, 2, 0);
    endtask

    task automatic test_wrap();
        fill_random();
        mem[0] = 32'h0000_0020;
        mem[1] = 32'hFFFF_FFF8;
        mem[254] = 32'h0000_0003;
        do_reset();
        build_model(32'h0, 6);
        pulse_start();
        drain(6, 0, 0);
        checks++;
        if (inst_addr !== 32'h8) begin
            failures++;
            $display("FAIL wrap_addr: got %h required 00000008", inst_addr);
        end
    endtask

    task automatic test_end_restart();
        fill_random();
        mem[0] = 32'h0000_00F0;
        mem[1] = 32'h0000_0042;
        mem[2] = 32'h0000_0021;
        do_reset();
        build_model(32'h0, 3);
        pulse_start();
        drain(3, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || inst_addr !== 32'h8) begin
            failures++;
            $display("FAIL end_halt: got done=%b busy=%b valid=%b addr=%h required 1 0 0 00000008", done, busy, out_valid, inst_addr);
        end
        build_model(32'h0, 3);
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || inst_addr !== 32'h0) begin
            failures++;
            $display("FAIL end_restart: got done=%b busy=%b addr=%h required 0 1 00000000", done, busy, inst_addr);
        end
        drain(3, 2, 0);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL end_done_again: got %b required 1", done);
        end
    endtask

    task automatic test_stall();
        fill_random();
        mem[0] = 32'h0000_0004;
        do_reset();
        build_model(32'h0, 4);
        pulse_start();
        drain(4, 0, 2);
    endtask

    task automatic test_reset_mid();
        fill_random();
        mem[0] = 32'h0000_0011;
        do_reset();
        build_model(32'h0, 9);
        pulse_start();
        drain(9, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd9) begin
            failures++;
            $display("FAIL mid_word9: got valid=%b idx=%0d required 1 9", out_valid, out_idx);
        end
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_reset_async");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_vals("mid_reset_quiet");
        build_model(32'h0, 3);
        pulse_start();
        drain(3, 2, 0);
    endtask

    task automatic test_random();
        logic [7:0] ops [10];
        logic [31:0] pc;
        int nw;
        logic [7:0] op;
        ops = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h77};
        for (int r = 0; r < 4; r++) begin
            fill_random();
            pc = 0;
            for (int c = 0; c < 8; c++) begin
                op = ops[$urandom_range(0, 9)];
                if (op == 8'h77) op = 8'h80 | 8'($urandom_range(0, 127));
                mem[pc[9:2]] = {$urandom_range(0, 32'h00FF_FFFF) & 32'h00FF_FFFF} << 8 | 32'(op);
                pc = pc + 32'(4 * cmd_len(op));
            end
            mem[pc[9:2]] = 32'h0000_0021;
            do_reset();
            build_model(32'h0, 200);
            nw = exp_q.size();
            pulse_start();
            drain(nw, 2, 1);
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL random_done: got done=%b busy=%b required 1 0", done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vertex();
        test_loadmatrix();
        test_jump();
        test_wrap();
        test_end_restart();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gl_fetch_stream.md
GL_FETCH_STREAM -- requirements
Module: gl_fetch_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction/payload word width.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter TEXT_START, default 0, byte address of the first command.
REQ-004 SHALL have parameter RESET_VALUE, default 0, value of out_word after reset.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins fetching at TEXT_START.
REQ-008 SHALL have port stall  input  1  global freeze of all state.
REQ-009 SHALL have port inst_in  input  DATA_W  BRAM read data, valid the cycle after inst_addr is presented.
REQ-010 SHALL have port inst_addr  output  ADDR_W  registered BRAM byte address.
REQ-011 SHALL have port out_word, out_valid, out_ready  output DATA_W / output 1 / input 1  downstream word stream with valid/ready handshake.
REQ-012 SHALL have port out_first, out_last  output  1 each  word is command header / final word of command.
REQ-013 SHALL have port out_idx  output  5  word index within current command (header = 0).
REQ-014 SHALL have port busy, done  output  1 each  fetching in progress / END command consumed.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LATCH, OUT, HALT.
REQ-016 IDLE: on start=1, load inst_addr=TEXT_START, word count 0, go FETCH.
REQ-017 FETCH: one cycle presenting inst_addr; go LATCH.
REQ-018 LATCH: register inst_in into out_word; if word count 0, decode inst_in[7:0] and load command length; go OUT.
REQ-019 Command length in words including header SHALL be: 8'h03 VERTEX 4; 8'h04 COLOR 4; 8'h11 MULTMATRIX, 8'h13 LOADMATRIX, 8'h16 ROTATE, 8'h17 SCALE, 8'h18 TRANSLATE 17; 8'h19 VIEWPORT 5; 8'h1A FRUSTUM 7; 8'h20 JUMP 2; 8'h21 END 1; any other opcode 1.
REQ-020 OUT: out_valid=1; out_word, out_first, out_last, out_idx SHALL stay stable until out_ready=1.
REQ-021 On OUT handshake with more words remaining: inst_addr += 4, word count += 1, go FETCH.
REQ-022 On OUT handshake of last word of a non-JUMP, non-END command: inst_addr += 4, word count = 0, go FETCH.
REQ-023 On OUT handshake of JUMP payload word: inst_addr = payload with bits [1:0] forced to 0, word count = 0, go FETCH.
REQ-024 On OUT handshake of END header: go HALT, done=1, busy=0.
REQ-025 HALT: inst_addr held; start=1 SHALL clear done and restart exactly as from IDLE.
REQ-026 Throughput SHALL be one word per 3 cycles when out_ready is held 1; first word valid 3 cycles after start.
REQ-027 busy SHALL be 1 in FETCH, LATCH, OUT; 0 in IDLE and HALT.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 stall=1 SHALL hold every register, including inst_addr and out_word, and SHALL take priority over start and out_ready in the same cycle; out_valid remains as held.
REQ-030 inst_addr arithmetic SHALL be modulo 2^ADDR_W (wraps from all-ones region to 0 without error).
REQ-031 out_last SHALL be 1 when out_idx equals command length minus 1; for 1-word commands out_first and out_last SHALL both be 1.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state IDLE, inst_addr=TEXT_START, out_word=RESET_VALUE, out_valid=0, out_first=0, out_last=0, out_idx=0, busy=0, done=0.
REQ-033 Reset asserted mid-command SHALL abandon the command; no partial word is emitted after release; fetching resumes only on next start.

Verification
REQ-034 VERTEX: start, memory word0=32'h03, words1-3 data, out_ready=1 -> 4 words, out_idx 0..3, first on idx0, last on idx3, next inst_addr=16.
REQ-035 LOADMATRIX with out_ready toggling 1/0 -> 17 words in order, each stable while out_ready=0, next header fetched from byte 68.
REQ-036 JUMP at 0 with payload 32'h0000_0103 -> 2 words emitted, next FETCH presents inst_addr=32'h100.
REQ-037 END at byte 8 after two unknown opcodes -> 3 one-word commands, done=1, busy=0; second start restarts at TEXT_START with done=0.
REQ-038 stall=1 for 5 cycles during OUT with out_ready=1 -> no handshake, all outputs frozen; handshake completes the cycle after stall drops.
REQ-039 reset_n pulsed low during word 9 of MULTMATRIX -> immediate IDLE reset values; after release and start, header fetched from TEXT_START.
